// File: rtl/emux_tx_sched.sv
// emux_tx_sched
// Head-of-chain scheduler for the Ethernet transmit client chain. Picks one
// requesting client at a time in round-robin order and emits the {m, p, octet}
// control stream: port high, port low (p strobe), two length octets, a data
// window of exactly L cycles (m high), then an inter-packet gap.

module emux_tx_sched #(
    parameter int                         n_clients = 4,
    parameter logic [n_clients*16-1:0]    ports     = {16'd1003, 16'd1002, 16'd1001, 16'd1000},
    parameter int                         jumbo_dw  = 14,
    parameter int                         ipg       = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [n_clients-1:0]           req,
    input  logic [n_clients*jumbo_dw-1:0]  len_flat,
    input  logic                           tx_ready,
    output logic [9:0]                     out_c,
    output logic                           grant,
    output logic [2:0]                     grant_idx,
    output logic                           busy
);

    // Shared DATA/GAP down-counter must hold both the largest length and ipg.
    localparam int IPG_W = $clog2(ipg + 1);
    localparam int CW    = (jumbo_dw > IPG_W) ? jumbo_dw : IPG_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    localparam logic [9:0] W_IDLE = 10'h000;
    localparam logic [9:0] W_DATA = 10'h200;

    // Control state
    logic [1:0]          state_q, state_d;
    logic [1:0]          hdr_q, hdr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          last_q, last_d;

    // Latched packet parameters (data path, not reset)
    logic [15:0]         port_q, port_d;
    logic [jumbo_dw-1:0] len_q, len_d;

    // Registered outputs
    logic [9:0]          out_q, out_d;
    logic                grant_q, grant_d;
    logic [2:0]          gidx_q, gidx_d;
    logic                busy_q, busy_d;

    // Per-client lookup tables padded to 8 entries so a 3-bit index is always legal
    logic [15:0]         port_tab [8];
    logic [jumbo_dw-1:0] len_tab  [8];
    logic [7:0]          req8;

    // Arbitration result
    logic [2:0]          win_idx;
    logic                win_vld;

    // Length as 16 bits: upper octet is L[jumbo_dw-1:8] zero-extended
    logic [15:0]         len_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tab
            if (gi < n_clients) begin : g_used
                assign port_tab[gi] = ports[16*gi +: 16];
                assign len_tab[gi]  = len_flat[jumbo_dw*gi +: jumbo_dw];
            end else begin : g_unused
                assign port_tab[gi] = 16'h0000;
                assign len_tab[gi]  = '0;
            end
        end
    endgenerate

    assign req8    = 8'(req);
    assign len_ext = 16'(len_q);

    // Round-robin search upward from last+1 with wrap; the smallest offset wins
    always_comb begin
        logic [3:0] cand;
        cand    = 4'd0;
        win_idx = 3'd0;
        win_vld = 1'b0;
        for (int off = n_clients; off >= 1; off--) begin
            cand = {1'b0, last_q} + 4'(off);
            if (cand >= 4'(n_clients)) begin
                cand = cand - 4'(n_clients);
            end
            if (req8[cand[2:0]]) begin
                win_idx = cand[2:0];
                win_vld = 1'b1;
            end
        end
    end

    // Next-state and next-output decode; outputs are registered so every word
    // appears one cycle after the decision that produced it
    always_comb begin
        logic arb_en;
        state_d = state_q;
        hdr_d   = hdr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        port_d  = port_q;
        len_d   = len_q;
        out_d   = W_IDLE;
        grant_d = 1'b0;
        gidx_d  = gidx_q;
        busy_d  = busy_q;
        arb_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                arb_en = 1'b1;
            end
            S_HDR: begin
                // hdr_q names the header word currently on out_c
                case (hdr_q)
                    2'd0: begin
                        out_d = {2'b01, port_q[7:0]};
                        hdr_d = 2'd1;
                    end
                    2'd1: begin
                        out_d = {2'b00, len_ext[15:8]};
                        hdr_d = 2'd2;
                    end
                    2'd2: begin
                        out_d = {2'b00, len_ext[7:0]};
                        hdr_d = 2'd3;
                    end
                    default: begin
                        if (len_q != '0) begin
                            state_d = S_DATA;
                            cnt_d   = CW'(len_q);
                            out_d   = W_DATA;
                        end else begin
                            // Zero-length packet skips the data window entirely
                            state_d = S_GAP;
                            cnt_d   = CW'(ipg);
                        end
                    end
                endcase
            end
            S_DATA: begin
                // cnt_q counts the data cycles left including the one on out_c
                if (cnt_q == CW'(1)) begin
                    state_d = S_GAP;
                    cnt_d   = CW'(ipg);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    out_d = W_DATA;
                end
            end
            default: begin
                // Last gap cycle doubles as an arbitration slot so packets can
                // run back to back with exactly ipg idle cycles between them
                if (cnt_q == CW'(1)) begin
                    arb_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase

        if (arb_en) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            if (tx_ready && win_vld) begin
                state_d = S_HDR;
                hdr_d   = 2'd0;
                busy_d  = 1'b1;
                grant_d = 1'b1;
                gidx_d  = win_idx;
                last_d  = win_idx;
                port_d  = port_tab[win_idx];
                len_d   = len_tab[win_idx];
                out_d   = {2'b00, port_tab[win_idx][15:8]};
            end
        end
    end

    // Control and output registers; reset drops any packet in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hdr_q   <= 2'd0;
            cnt_q   <= '0;
            last_q  <= 3'(n_clients - 1);
            out_q   <= W_IDLE;
            grant_q <= 1'b0;
            gidx_q  <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            out_q   <= out_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            busy_q  <= busy_d;
        end
    end

    // Latched port and length of the granted client; only meaningful while busy
    always_ff @(posedge clk) begin
        port_q <= port_d;
        len_q  <= len_d;
    end

    assign out_c     = out_q;
    assign grant     = grant_q;
    assign grant_idx = gidx_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_emux_tx_sched.sv
// Testbench for emux_tx_sched: a packet-level reference model pushes expected
// grants into a queue; a monitor pops them on each DUT grant and checks every
// output cycle of the packet, plus idle behaviour between packets.

module tb_emux_tx_sched;

    localparam int N   = 4;
    localparam int JDW = 14;
    localparam int IPG = 12;
    localparam logic [N*16-1:0] PORTS_FLAT = {16'hA5C3, 16'h00FF, 16'h5678, 16'h1234};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*JDW-1:0] len_flat = '0;
    logic             tx_ready = 1'b0;
    logic [9:0]       out_c;
    logic             grant;
    logic [2:0]       grant_idx;
    logic             busy;

    emux_tx_sched #(
        .n_clients (N),
        .ports     (PORTS_FLAT),
        .jumbo_dw  (JDW),
        .ipg       (IPG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len_flat  (len_flat),
        .tx_ready  (tx_ready),
        .out_c     (out_c),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int len;
        int start;
    } pkt_t;

    pkt_t exp_q[$];
    int   cyc      = 0;
    int   rst_cyc  = -1;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int port_of(input int i);
        return int'(PORTS_FLAT[16*i +: 16]);
    endfunction

    // Expected out_c for a given offset into a packet
    function automatic logic [9:0] exp_word(input pkt_t p, input int off);
        int pt;
        pt = port_of(p.idx);
        if (off == 0) return {2'b00, 8'((pt >> 8) & 255)};
        if (off == 1) return {2'b01, 8'(pt & 255)};
        if (off == 2) return {2'b00, 8'((p.len >> 8) & 255)};
        if (off == 3) return {2'b00, 8'(p.len & 255)};
        if (off < 4 + p.len) return 10'h200;
        return 10'h000;
    endfunction

    // Reference model: one packet occupies 4+L+IPG cycles; round-robin from last+1
    initial begin : model
        int last;
        int free_at;
        int w;
        int j;
        int l;
        last    = N - 1;
        free_at = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                rst_cyc = cyc;
                last    = N - 1;
                free_at = cyc + 1;
                exp_q.delete();
            end else if (cyc >= free_at && tx_ready && req != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    j = (last + k) % N;
                    if (w < 0 && ((req >> j) & N'(1)) != '0) w = j;
                end
                l = int'(len_flat[w*JDW +: JDW]);
                exp_q.push_back('{w, l, cyc});
                last    = w;
                free_at = cyc + 4 + l + IPG;
            end
        end
    end

    // Monitor: samples 1 time unit after each rising edge
    initial begin : monitor
        pkt_t cur;
        int   held;
        int   off;
        int   mcount;
        held   = 0;
        mcount = 0;
        cur    = '{0, 0, 0};
        forever begin
            @(posedge clk);
            #1;
            if (rst_cyc == cyc) begin
                check("reset_outputs", 32'({busy, grant, grant_idx, out_c}), 32'h0);
                mon_busy = 1'b0;
                held     = 0;
                continue;
            end
            if (grant && !mon_busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL grant_unexpected at cycle %0d: got grant idx %0d, expected no grant", cyc, grant_idx);
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_cycle", cyc, cur.start);
                    mon_busy = 1'b1;
                    mcount   = 0;
                    held     = cur.idx;
                end
            end
            if (!mon_busy && exp_q.size() > 0 && exp_q[0].start < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL grant_missing at cycle %0d: got no grant, expected grant idx %0d at cycle %0d",
                         cyc, exp_q[0].idx, exp_q[0].start);
                void'(exp_q.pop_front());
            end
            if (mon_busy) begin
                off = cyc - cur.start;
                check("pkt_word", 32'({busy, grant, grant_idx, out_c}),
                      32'({1'b1, off == 0, 3'(cur.idx), exp_word(cur, off)}));
                if (out_c[9]) mcount++;
                if (off == 3 + cur.len + IPG) begin
                    check("m_cycles", mcount, cur.len);
                    mon_busy = 1'b0;
                end
            end else begin
                check("idle_outputs", 32'({busy, grant, grant_idx, out_c}),
                      32'({1'b0, 1'b0, 3'(held), 10'h000}));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_len(input int i, input int v);
        len_flat[i*JDW +: JDW] = JDW'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // Stimulus
    initial begin : stim
        rst      = 1'b1;
        req      = '0;
        tx_ready = 1'b1;
        tick(3);
        rst = 1'b0;

        // Single packet: client 0, port 0x1234, L=3
        set_len(0, 3);
        req = 4'b0001;
        tick(1);
        req = '0;
        tick(25);

        // Round-robin among clients 0, 1, 3 with L=1
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 1);
        req = 4'b1011;
        tick(6 * 17);
        req = '0;
        tick(20);

        // Zero length on client 2 (port 0x00FF)
        set_len(2, 0);
        req = 4'b0100;
        tick(1);
        req = '0;
        tick(25);

        // Jumbo length on client 1
        set_len(1, 'h2345);
        req = 4'b0010;
        tick(1);
        req = '0;
        tick(9029 + 30);

        // Flow control: request held with tx_ready low, then a one-cycle ready
        tx_ready = 1'b0;
        set_len(0, 5);
        req = 4'b0001;
        tick(20);
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        tick(1);
        req = '0;
        tick(30);
        tx_ready = 1'b1;

        // Reset during the second data cycle of an L=10 packet
        set_len(0, 10);
        req = 4'b0001;
        tick(1);
        req = '0;
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_len(i, $urandom_range(0, 20));
        req = 4'b1111;
        tick(1);
        req = '0;
        tick(40);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 499) == 0);
            req      = N'($urandom);
            tx_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) set_len(i, $urandom_range(0, 40));
            tick(1);
        end
        rst      = 1'b0;
        req      = '0;
        tx_ready = 1'b1;
        tick(80);

        check("drain_pending", exp_q.size() + int'(mon_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
